// File: rtl/add_seq_pkg.sv
// rtl/add_seq_pkg.sv - shared encodings for the time-shared 16-bit adder sequencer
package add_seq_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    localparam int MUL_ITER = 16;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LO   = 3'd1,
        S_HI   = 3'd2,
        S_MUL  = 3'd3,
        S_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/add16_seq_ctrl.sv
// rtl/add16_seq_ctrl.sv - multicycle ADD32/SUB32/MULU16 sequencer around one external W-bit adder
module add16_seq_ctrl
    import add_seq_pkg::*;
#(
    parameter int W = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [1:0]     op,
    input  logic [2*W-1:0] a,
    input  logic [2*W-1:0] b,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] result,
    output logic           carry,
    output logic [W-1:0]   add_a,
    output logic [W-1:0]   add_b,
    output logic           add_cin,
    input  logic [W-1:0]   add_s,
    input  logic           add_cout
);

    localparam int CW = $clog2(MUL_ITER);
    localparam logic [CW-1:0] LAST = CW'(MUL_ITER - 1);

    state_t          state, next_state;
    logic [1:0]      op_r;
    logic [2*W-1:0]  a_r, b_r;
    logic [W-1:0]    lo_reg;
    logic            c_reg;
    logic [W-1:0]    ph, pl;
    logic [CW-1:0]   count;
    logic            accept;
    logic            is_sub;

    assign is_sub = (op_r == OP_SUB);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        add_a      = '0;
        add_b      = '0;
        add_cin    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                done       = (state == S_DONE);
                accept     = start;
                next_state = S_IDLE;
                if (start) begin
                    case (op)
                        OP_ADD, OP_SUB: next_state = S_LO;
                        OP_MUL:         next_state = S_MUL;
                        default:        next_state = S_DONE;
                    endcase
                end
            end
            S_LO: begin
                busy       = 1'b1;
                add_a      = a_r[W-1:0];
                add_b      = is_sub ? ~b_r[W-1:0] : b_r[W-1:0];
                add_cin    = is_sub;
                next_state = S_HI;
            end
            S_HI: begin
                busy       = 1'b1;
                add_a      = a_r[2*W-1:W];
                add_b      = is_sub ? ~b_r[2*W-1:W] : b_r[2*W-1:W];
                add_cin    = c_reg;
                next_state = S_DONE;
            end
            S_MUL: begin
                busy       = 1'b1;
                add_a      = ph;
                add_b      = pl[0] ? b_r[W-1:0] : '0;
                if (count == LAST) begin
                    next_state = S_DONE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Shift-add multiply: the adder output and carry shift down into ph, ph's LSB into pl
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r   <= '0;
            a_r    <= '0;
            b_r    <= '0;
            lo_reg <= '0;
            c_reg  <= 1'b0;
            ph     <= '0;
            pl     <= '0;
            count  <= '0;
            result <= '0;
            carry  <= 1'b0;
        end else if (accept) begin
            op_r  <= op;
            a_r   <= a;
            b_r   <= b;
            ph    <= '0;
            pl    <= a[W-1:0];
            count <= '0;
            if (op == OP_RSV) begin
                result <= '0;
                carry  <= 1'b0;
            end
        end else begin
            case (state)
                S_LO: begin
                    lo_reg <= add_s;
                    c_reg  <= add_cout;
                end
                S_HI: begin
                    result <= {add_s, lo_reg};
                    carry  <= add_cout;
                end
                S_MUL: begin
                    ph    <= {add_cout, add_s[W-1:1]};
                    pl    <= {add_s[0], pl[W-1:1]};
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        result <= {add_cout, add_s, pl[W-1:1]};
                        carry  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_add16_seq_ctrl.sv
// tb/tb_add16_seq_ctrl.sv - scoreboard bench for add16_seq_ctrl with a real 16-bit adder
module tb_add16_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0, b = '0;
    logic        busy, done, carry, add_cin, add_cout;
    logic [31:0] result;
    logic [15:0] add_a, add_b, add_s;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] res;
        logic        c;
        int          lat;
        int          t;
    } exp_t;
    exp_t sb[$];

    add16_seq_ctrl #(.W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .carry(carry),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_s(add_s), .add_cout(add_cout)
    );

    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {16'h0, add_cin};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expected response
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=%h required=none", result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", result, e.res);
                chk("carry", 32'(carry), 32'(e.c));
                chk("latency", 32'(cyc + 1 - e.t), 32'(e.lat));
            end
        end
    end

    // Called at a negedge; start is sampled at the following posedge (edge t)
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] res, input logic c, input int lat, input bit expect_done);
        exp_t e;
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e.res = res; e.c = c; e.lat = lat; e.t = cyc;
        if (expect_done) sb.push_back(e);
    endtask

    // Leaves the caller at the negedge where done is high; returns busy cycles seen
    task automatic wait_done(output int busy_cnt);
        int n;
        busy_cnt = 0;
        n = 0;
        @(negedge clk);
        while (!done && n < 40) begin
            if (busy) busy_cnt++;
            n++;
            @(negedge clk);
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=0 required=1");
        end
    endtask

    initial begin
        int bc;
        repeat (2) @(negedge clk);
        chk("rst_result", result, 32'h0);
        chk("rst_flags", {29'h0, busy, done, carry}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        issue(2'b00, 32'h0001_FFFF, 32'h0000_0001, 32'h0002_0000, 1'b0, 3, 1'b1);
        wait_done(bc);
        chk("add_busy_cycles", 32'(bc), 32'd2);
        @(negedge clk);

        issue(2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 3, 1'b1);
        wait_done(bc); @(negedge clk);
        issue(2'b01, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 3, 1'b1);
        wait_done(bc); @(negedge clk);
        issue(2'b01, 32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b1, 3, 1'b1);
        wait_done(bc); @(negedge clk);
        issue(2'b10, 32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001, 1'b0, 17, 1'b1);
        wait_done(bc); @(negedge clk);
        issue(2'b10, 32'h0000_1234, 32'h0000_0000, 32'h0000_0000, 1'b0, 17, 1'b1);
        wait_done(bc); @(negedge clk);

        // Start during MUL cycle 5 must be ignored
        issue(2'b10, 32'hABCD_0003, 32'h9999_0005, 32'h0000_000F, 1'b0, 17, 1'b1);
        repeat (4) @(negedge clk);
        issue(2'b00, 32'h1111_1111, 32'h2222_2222, 32'h0, 1'b0, 0, 1'b0);
        wait_done(bc);

        // Back-to-back: start held in the DONE cycle
        issue(2'b00, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 1'b0, 3, 1'b1);
        wait_done(bc);
        issue(2'b10, 32'h0000_1234, 32'h0000_0010, 32'h0001_2340, 1'b0, 17, 1'b1);
        wait_done(bc);
        issue(2'b01, 32'h0000_0010, 32'h0000_0010, 32'h0000_0000, 1'b1, 3, 1'b1);
        wait_done(bc); @(negedge clk);

        // Reset during MUL cycle 8 aborts without a done
        issue(2'b10, 32'h0000_00FF, 32'h0000_00FF, 32'h0, 1'b0, 0, 1'b0);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_result", result, 32'h0);
        chk("midrst_flags", {29'h0, busy, done, carry}, 32'h0);
        chk("midrst_adder", {add_a, add_b[14:0], add_cin}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("midrst_idle_busy", 32'(busy), 32'h0);
        issue(2'b00, 32'h0000_0003, 32'h0000_0004, 32'h0000_0007, 1'b0, 3, 1'b1);
        wait_done(bc); @(negedge clk);

        // Reserved op: immediate done, adder inputs idle
        issue(2'b11, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0, 1'b0, 1, 1'b1);
        chk("rsv_adder", {add_a, add_b[14:0], add_cin}, 32'h0);
        wait_done(bc);
        chk("rsv_adder_done", {add_a, add_b[14:0], add_cin}, 32'h0);
        repeat (3) @(negedge clk);

        chk("scoreboard_empty", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
